// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the shift-add multiplier.
package alu_pkg;

  localparam logic [5:0] ALU_OP_MULN = 6'd15;
  localparam logic [5:0] ALU_OP_MULZ = 6'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    NEGATE  = 2'd2,
    READY   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_pipelined_mul_if.sv
// Valid/ack data channel: the producer holds data while valid, the consumer pulses ack.
interface data_interface #(
  parameter int unsigned WIDTH = 32
) ();

  logic             valid;
  logic             ack;
  logic [WIDTH-1:0] data;

  modport consumer (input valid, input data, output ack);
  modport producer (output valid, output data, input ack);

endinterface

// File: rtl/alu_pipelined_mul.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, with signed fix-up
// by a final two's-complement negate of the full-width product.
module alu_pipelined_mul #(
  parameter int unsigned                 DATA_WIDTH   = 32,
  parameter int unsigned                 OPCODE_WIDTH = 6,
  parameter logic [OPCODE_WIDTH-1:0]     ALU_OP_MULN  = OPCODE_WIDTH'(alu_pkg::ALU_OP_MULN),
  parameter logic [OPCODE_WIDTH-1:0]     ALU_OP_MULZ  = OPCODE_WIDTH'(alu_pkg::ALU_OP_MULZ)
) (
  input  logic                   clock,
  input  logic                   reset,
  data_interface.consumer        operator,
  data_interface.consumer        left,
  data_interface.consumer        right,
  data_interface.producer        result,
  data_interface.producer        overflow
);

  import alu_pkg::*;

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e                    r_state;
  logic                      r_is_mulz;
  logic                      r_neg;
  logic                      r_res_valid;
  logic                      r_ovf_valid;
  logic [2*DATA_WIDTH-1:0]   r_acc;
  logic [2*DATA_WIDTH-1:0]   r_mcand;
  logic [DATA_WIDTH-1:0]     r_mplier;
  logic [CntW-1:0]           r_count;

  logic                      w_ack;
  logic                      w_is_mulz;
  logic                      w_res_done;
  logic                      w_ovf_done;
  logic [DATA_WIDTH-1:0]     w_left_mag;
  logic [DATA_WIDTH-1:0]     w_right_mag;

  assign w_ack = operator.valid & left.valid & right.valid & (r_state == IDLE) & ~reset;
  assign operator.ack = w_ack;
  assign left.ack     = w_ack;
  assign right.ack    = w_ack;

  // Degenerate MULN==MULZ parameterisation falls back to unsigned.
  assign w_is_mulz = (operator.data == ALU_OP_MULZ) && (ALU_OP_MULN != ALU_OP_MULZ);

  // Magnitude of the most-negative value wraps to 2^(W-1), which is correct read unsigned.
  assign w_left_mag  = (w_is_mulz && left.data[DATA_WIDTH-1])  ? -left.data  : left.data;
  assign w_right_mag = (w_is_mulz && right.data[DATA_WIDTH-1]) ? -right.data : right.data;

  assign w_res_done = ~r_res_valid | result.ack;
  assign w_ovf_done = ~r_ovf_valid | overflow.ack;

  assign result.valid   = r_res_valid;
  assign result.data    = r_acc[DATA_WIDTH-1:0];
  assign overflow.valid = r_ovf_valid;
  assign overflow.data  = r_acc[2*DATA_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_is_mulz   <= 1'b0;
      r_neg       <= 1'b0;
      r_res_valid <= 1'b0;
      r_ovf_valid <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ack) begin
            r_is_mulz <= w_is_mulz;
            r_neg     <= w_is_mulz & (left.data[DATA_WIDTH-1] ^ right.data[DATA_WIDTH-1]);
            r_mcand   <= {{DATA_WIDTH{1'b0}}, w_left_mag};
            r_mplier  <= w_right_mag;
            r_acc     <= '0;
            r_count   <= CntW'(DATA_WIDTH - 1);
            r_state   <= RUNNING;
          end
        end
        RUNNING: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_count == '0) begin
            if (r_is_mulz) begin
              r_state <= NEGATE;
            end else begin
              r_state     <= READY;
              r_res_valid <= 1'b1;
              r_ovf_valid <= 1'b1;
            end
          end else begin
            r_count <= r_count - CntW'(1);
          end
        end
        NEGATE: begin
          if (r_neg) r_acc <= -r_acc;
          r_state     <= READY;
          r_res_valid <= 1'b1;
          r_ovf_valid <= 1'b1;
        end
        READY: begin
          if (result.ack)   r_res_valid <= 1'b0;
          if (overflow.ack) r_ovf_valid <= 1'b0;
          if (w_res_done && w_ovf_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipelined_mul.sv
// Directed bench for alu_pipelined_mul: latency, signed/unsigned products, handshake, reset.
module tb_alu_pipelined_mul;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  data_interface #(.WIDTH(6))  op_if ();
  data_interface #(.WIDTH(32)) l_if ();
  data_interface #(.WIDTH(32)) r_if ();
  data_interface #(.WIDTH(32)) res_if ();
  data_interface #(.WIDTH(32)) ovf_if ();

  alu_pipelined_mul dut (
    .clock    (clk),
    .reset    (rst),
    .operator (op_if),
    .left     (l_if),
    .right    (r_if),
    .result   (res_if),
    .overflow (ovf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation at a negedge and check it is taken on the next rising edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_if.data = op; l_if.data = a; r_if.data = b;
    op_if.valid = 1'b1; l_if.valid = 1'b1; r_if.valid = 1'b1;
    #1;
    n_checks++;
    if (!(op_if.ack && l_if.ack && r_if.ack)) begin
      n_fail++;
      $display("FAIL issue_ack: got %b%b%b expected 111", op_if.ack, l_if.ack, r_if.ack);
    end
    @(posedge clk);
    #1;
    op_if.valid = 1'b0; l_if.valid = 1'b0; r_if.valid = 1'b0;
  endtask

  // Returns the cycle index (ack cycle = 0) at which result.valid is first seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!res_if.valid && cyc < 60);
  endtask

  task automatic drain_both();
    res_if.ack = 1'b1; ovf_if.ack = 1'b1;
    @(posedge clk);
    #1;
    res_if.ack = 1'b0; ovf_if.ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.r_state !== IDLE || res_if.valid !== 1'b0 || ovf_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: got state=%0d rv=%b ov=%b expected state=0 rv=0 ov=0",
               dut.r_state, res_if.valid, ovf_if.valid);
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic [31:0] exp_ovf);
    int cyc;
    issue(op, a, b);
    wait_valid(cyc);
    n_checks++;
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_lat);
    end
    n_checks++;
    if (ovf_if.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid_together: got overflow.valid=%b expected 1", name, ovf_if.valid);
    end
    n_checks++;
    if (res_if.data !== exp_res || ovf_if.data !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s_product: got %h_%h expected %h_%h", name, ovf_if.data, res_if.data,
               exp_ovf, exp_res);
    end
    drain_both();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op_if.valid = 1'b1; l_if.valid = 1'b1; r_if.valid = 1'b1;
    op_if.data = ALU_OP_MULN; l_if.data = 32'd1; r_if.data = 32'd1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut.r_state !== IDLE || dut.r_acc !== 64'd0 || dut.r_count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d acc=%h cnt=%0d expected 0 0 0",
               dut.r_state, dut.r_acc, dut.r_count);
    end
    n_checks++;
    if (res_if.valid !== 1'b0 || ovf_if.valid !== 1'b0 || op_if.ack !== 1'b0 ||
        l_if.ack !== 1'b0 || r_if.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%b ov=%b acks=%b%b%b expected all 0",
               res_if.valid, ovf_if.valid, op_if.ack, l_if.ack, r_if.ack);
    end
    op_if.valid = 1'b0; l_if.valid = 1'b0; r_if.valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_partial_valid();
    int bad_ack;
    bad_ack = 0;
    @(negedge clk);
    l_if.data = 32'd5; r_if.data = 32'd4; op_if.data = ALU_OP_MULN;
    l_if.valid = 1'b1; r_if.valid = 1'b1;
    repeat (10) begin
      #1;
      if (op_if.ack || l_if.ack || r_if.ack || dut.r_state !== IDLE) bad_ack++;
      @(negedge clk);
    end
    n_checks++;
    if (bad_ack != 0) begin
      n_fail++;
      $display("FAIL partial_no_ack: got %0d bad cycles expected 0", bad_ack);
    end
    op_if.valid = 1'b1;
    #1;
    n_checks++;
    if ({op_if.ack, l_if.ack, r_if.ack} !== 3'b111) begin
      n_fail++;
      $display("FAIL partial_joint_ack: got %b%b%b expected 111", op_if.ack, l_if.ack, r_if.ack);
    end
    @(posedge clk);
    #1;
    op_if.valid = 1'b0; l_if.valid = 1'b0; r_if.valid = 1'b0;
    begin
      int cyc;
      wait_valid(cyc);
      n_checks++;
      if (res_if.data !== 32'd20 || cyc != 33) begin
        n_fail++;
        $display("FAIL partial_product: got %0d at %0d expected 20 at 33", res_if.data, cyc);
      end
    end
    drain_both();
  endtask

  task automatic test_split_ack();
    int cyc;
    int bad;
    bad = 0;
    issue(ALU_OP_MULN, 32'd6, 32'd7);
    wait_valid(cyc);
    // Cycle N: ack result only; offer new inputs during READY, which must not be taken.
    res_if.ack = 1'b1;
    op_if.data = ALU_OP_MULN; l_if.data = 32'd1; r_if.data = 32'd1;
    op_if.valid = 1'b1; l_if.valid = 1'b1; r_if.valid = 1'b1;
    @(posedge clk);
    #1;
    res_if.ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (res_if.valid !== 1'b0 || ovf_if.valid !== 1'b1 || dut.r_state !== READY) bad++;
      if (op_if.ack || l_if.ack || r_if.ack) bad++;
      if (k == 3) ovf_if.ack = 1'b1;
      #1;
      if (op_if.ack || l_if.ack || r_if.ack) bad++;
    end
    @(posedge clk);
    #1;
    ovf_if.ack = 1'b0;
    op_if.valid = 1'b0; l_if.valid = 1'b0; r_if.valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL split_ready_hold: got %0d bad samples expected 0", bad);
    end
    @(negedge clk);
    n_checks++;
    if (ovf_if.valid !== 1'b0 || dut.r_state !== IDLE) begin
      n_fail++;
      $display("FAIL split_exit: got ov=%b state=%0d expected ov=0 state=0",
               ovf_if.valid, dut.r_state);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int cyc;
    issue(ALU_OP_MULN, 32'd100, 32'd100);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut.r_state !== IDLE || res_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_running: got state=%0d rv=%b expected 0 0",
               dut.r_state, res_if.valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset in READY must also drop the pending valids at once.
    issue(ALU_OP_MULZ, 32'hFFFF_FFFF, 32'd1);
    wait_valid(cyc);
    rst = 1'b1;
    #1;
    n_checks++;
    if (res_if.valid !== 1'b0 || ovf_if.valid !== 1'b0 || dut.r_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_ready: got rv=%b ov=%b state=%0d expected 0 0 0",
               res_if.valid, ovf_if.valid, dut.r_state);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_if.valid || ovf_if.valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_no_stale_valid: got %0d valid cycles expected 0", seen);
    end
    run_op("post_reset", ALU_OP_MULN, 32'd2, 32'd3, 33, 32'd6, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    op_if.valid = 1'b0; l_if.valid = 1'b0; r_if.valid = 1'b0;
    op_if.data = '0; l_if.data = '0; r_if.data = '0;
    res_if.ack = 1'b0; ovf_if.ack = 1'b0;

    test_reset();
    run_op("muln_7x9",  ALU_OP_MULN, 32'd7, 32'd9, 33, 32'd63, 32'd0);
    run_op("muln_max",  ALU_OP_MULN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mulz_m3x5", ALU_OP_MULZ, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
    run_op("mulz_minsq", ALU_OP_MULZ, 32'h8000_0000, 32'h8000_0000, 34,
           32'h0000_0000, 32'h4000_0000);
    run_op("mulz_m3xm5", ALU_OP_MULZ, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 34, 32'd15, 32'd0);
    run_op("mulz_zero", ALU_OP_MULZ, 32'hFFFF_FFFD, 32'd0, 34, 32'd0, 32'd0);
    run_op("other_op",  6'd3, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE, 32'd1);
    test_split_ack();
    test_partial_valid();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
